// File: rtl/vga_timing_if.sv
// Pixel-side signal bundle between the VGA timing driver (master) and the
// renderer/pin consumer (slave).
interface vga_timing_if;
  logic [7:0] COLOUR_IN;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic       HS;
  logic       VS;
  logic [7:0] COLOUR_OUT;
  logic       PIX_TICK;
  logic       FRAME_START;

  modport master (
    input  COLOUR_IN,
    output ADDRH, ADDRV, HS, VS, COLOUR_OUT, PIX_TICK, FRAME_START
  );

  modport slave (
    output COLOUR_IN,
    input  ADDRH, ADDRV, HS, VS, COLOUR_OUT, PIX_TICK, FRAME_START
  );
endinterface

// File: rtl/vga_timing_driver.sv
// Raster-scan VGA timing generator: divides CLK down to the pixel rate, presents
// pixel addresses to the renderer and registers colour/sync one pixel later.
module vga_timing_driver #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic         CLK,
  input  logic         RESET,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = V_VISIBLE + V_FRONT + V_SYNC - 1;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic [9:0]       addrh_q, addrh_d;
  logic [8:0]       addrv_q, addrv_d;
  logic [7:0]       colour_q, colour_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             pix_q, pix_d;
  logic             frame_q, frame_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic pre_visible;

  assign tick        = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_wrap      = (hcnt_q == 10'(H_TOTAL - 1));
  assign v_wrap      = (vcnt_q == 10'(V_TOTAL - 1));
  assign pre_visible = (hcnt_q < 10'(H_VISIBLE)) && (vcnt_q < 10'(V_VISIBLE));

  always_comb begin
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    colour_d = colour_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    pix_d    = tick;
    frame_d  = tick && h_wrap && v_wrap;

    if (tick) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = v_wrap ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      // Colour and sync come from the pre-tick counters so they line up with
      // the pixel whose address was presented one pixel period earlier.
      colour_d = pre_visible ? vga.COLOUR_IN : '0;
      hs_d     = !((hcnt_q >= 10'(HS_START)) && (hcnt_q <= 10'(HS_END)));
      vs_d     = !((vcnt_q >= 10'(VS_START)) && (vcnt_q <= 10'(VS_END)));
    end

    // Addresses follow the post-tick counters; between ticks they hold.
    addrh_d = (hcnt_d < 10'(H_VISIBLE)) ? hcnt_d : '0;
    addrv_d = (vcnt_d < 10'(V_VISIBLE)) ? vcnt_d[8:0] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addrh_q  <= '0;
      addrv_q  <= '0;
      colour_q <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      pix_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      addrh_q  <= addrh_d;
      addrv_q  <= addrv_d;
      colour_q <= colour_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      pix_q    <= pix_d;
      frame_q  <= frame_d;
    end
  end

  assign vga.ADDRH       = addrh_q;
  assign vga.ADDRV       = addrv_q;
  assign vga.HS          = hs_q;
  assign vga.VS          = vs_q;
  assign vga.COLOUR_OUT  = colour_q;
  assign vga.PIX_TICK    = pix_q;
  assign vga.FRAME_START = frame_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Self-checking bench for vga_timing_driver on a reduced raster; expectations
// come from a pixel-index model (tick n -> position n mod line/frame length).
module tb_vga_timing_driver;

  localparam int unsigned CDIV = 4;
  localparam int unsigned HV   = 16;
  localparam int unsigned HF   = 2;
  localparam int unsigned HSW  = 3;
  localparam int unsigned HB   = 3;
  localparam int unsigned VV   = 10;
  localparam int unsigned VF   = 2;
  localparam int unsigned VSW  = 2;
  localparam int unsigned VB   = 3;
  localparam int unsigned HT   = HV + HF + HSW + HB;
  localparam int unsigned VT   = VV + VF + VSW + VB;
  localparam int unsigned FT   = HT * VT;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  vga_timing_if vif ();

  vga_timing_driver #(
    .CLK_DIV(CDIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .vga(vif)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned n_ticks = 0;
  int unsigned mode = 0;   // 0: constant colour, 1: random, 2: renderer (ADDRH low byte)
  logic [7:0]  col_const = 8'h00;

  // ---------------- reference model: pixel index -> raster position ----------
  function automatic int unsigned hpos(input int unsigned n);
    return n % HT;
  endfunction
  function automatic int unsigned vpos(input int unsigned n);
    return (n / HT) % VT;
  endfunction
  function automatic bit vis(input int unsigned n);
    return (hpos(n) < HV) && (vpos(n) < VV);
  endfunction
  function automatic bit hs_low(input int unsigned n);
    return (hpos(n) >= HV + HF) && (hpos(n) < HV + HF + HSW);
  endfunction
  function automatic bit vs_low(input int unsigned n);
    return (vpos(n) >= VV + VF) && (vpos(n) < VV + VF + VSW);
  endfunction
  function automatic logic [9:0] exp_addrh(input int unsigned n);
    return (hpos(n) < HV) ? 10'(hpos(n)) : 10'd0;
  endfunction
  function automatic logic [8:0] exp_addrv(input int unsigned n);
    return (vpos(n) < VV) ? 9'(vpos(n)) : 9'd0;
  endfunction

  // Drives COLOUR_IN each cycle and waits (bounded) for the next PIX_TICK.
  // smp is the COLOUR_IN value present at the tick edge.
  task automatic next_tick(output bit got, output int unsigned cyc,
                           output bit stray, output logic [7:0] smp);
    got = 1'b0; cyc = 0; stray = 1'b0; smp = 8'h00;
    while (!got && cyc < 2 * CDIV) begin
      case (mode)
        1:       vif.COLOUR_IN = 8'($urandom);
        2:       vif.COLOUR_IN = vif.ADDRH[7:0];
        default: vif.COLOUR_IN = col_const;
      endcase
      smp = vif.COLOUR_IN;
      @(negedge CLK);
      cyc++;
      if (vif.PIX_TICK) got = 1'b1;
      else if (vif.FRAME_START) stray = 1'b1;
    end
    if (got) n_ticks++;
  endtask

  task automatic do_reset(input int unsigned cyc);
    RESET = 1'b1;
    repeat (cyc) @(negedge CLK);
    RESET = 1'b0;
    n_ticks = 0;
  endtask

  // ---------------- tests -----------------------------------------------------
  task automatic test_reset();
    logic [29:0] obs;
    mode = 0; col_const = 8'hFF; vif.COLOUR_IN = 8'hFF;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      obs = {vif.ADDRH, vif.ADDRV, vif.HS, vif.VS, vif.COLOUR_OUT, vif.PIX_TICK, vif.FRAME_START};
      checks++;
      if (obs !== {10'd0, 9'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_values cycle=%0d got=%h want=%h", i, obs,
                 {10'd0, 9'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
      end
    end
    RESET = 1'b0;
    n_ticks = 0;
    for (int unsigned c = 1; c <= CDIV; c++) begin
      @(negedge CLK);
      checks++;
      if (vif.PIX_TICK !== (c == CDIV)) begin
        failures++;
        $display("FAIL first_tick_phase cycle=%0d got=%b want=%b", c, vif.PIX_TICK, (c == CDIV));
      end
    end
    checks++;
    if ({vif.ADDRH, vif.ADDRV} !== {10'd1, 9'd0}) begin
      failures++;
      $display("FAIL first_tick_addr got=(%0d,%0d) want=(1,0)", vif.ADDRH, vif.ADDRV);
    end
    checks++;
    if ({vif.HS, vif.VS, vif.COLOUR_OUT} !== {1'b1, 1'b1, 8'hFF}) begin
      failures++;
      $display("FAIL first_tick_out got=%b%b/%h want=11/ff", vif.HS, vif.VS, vif.COLOUR_OUT);
    end
    @(negedge CLK);
    checks++;
    if (vif.PIX_TICK !== 1'b0) begin
      failures++;
      $display("FAIL tick_width got=%b want=0", vif.PIX_TICK);
    end
  endtask

  task automatic test_line();
    bit got, stray; int unsigned cyc; logic [7:0] smp;
    int unsigned ff_cnt, hs_cnt;
    int first_hs;
    ff_cnt = 0; hs_cnt = 0; first_hs = -1;
    mode = 0; col_const = 8'hFF;
    do_reset(2);
    for (int unsigned k = 0; k < HT; k++) begin
      next_tick(got, cyc, stray, smp);
      checks++;
      if (cyc !== CDIV) begin
        failures++;
        $display("FAIL line_tick_period got=%0d want=%0d", cyc, CDIV);
        return;
      end
      checks++;
      if (vif.COLOUR_OUT !== (vis(n_ticks - 1) ? smp : 8'h00)) begin
        failures++;
        $display("FAIL line_colour h=%0d got=%h want=%h", k, vif.COLOUR_OUT,
                 vis(n_ticks - 1) ? smp : 8'h00);
      end
      checks++;
      if (vif.HS !== !hs_low(n_ticks - 1)) begin
        failures++;
        $display("FAIL line_hs h=%0d got=%b want=%b", k, vif.HS, !hs_low(n_ticks - 1));
      end
      if (vif.COLOUR_OUT === 8'hFF) ff_cnt++;
      if (vif.HS === 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = int'(k);
      end
    end
    checks++;
    if (ff_cnt !== HV) begin
      failures++;
      $display("FAIL line_ff_count got=%0d want=%0d", ff_cnt, HV);
    end
    checks++;
    if (hs_cnt !== HSW) begin
      failures++;
      $display("FAIL line_hs_width got=%0d want=%0d", hs_cnt, HSW);
    end
    checks++;
    if (first_hs !== int'(HV + HF)) begin
      failures++;
      $display("FAIL line_hs_start got=%0d want=%0d", first_hs, HV + HF);
    end
  endtask

  task automatic test_frame();
    bit got, stray; int unsigned cyc; logic [7:0] smp;
    int unsigned last_fs, vs_cnt, max_h, max_v, fs_seen;
    last_fs = 0; vs_cnt = 0; max_h = 0; max_v = 0; fs_seen = 0;
    mode = 1;
    do_reset(2);
    for (int unsigned k = 0; k < 2 * FT + 5; k++) begin
      next_tick(got, cyc, stray, smp);
      checks++;
      if (cyc !== CDIV || stray) begin
        failures++;
        $display("FAIL frame_tick got_cyc=%0d stray_fs=%b want_cyc=%0d stray_fs=0", cyc, stray, CDIV);
        if (!got) return;
      end
      checks++;
      if ({vif.ADDRH, vif.ADDRV} !== {exp_addrh(n_ticks), exp_addrv(n_ticks)}) begin
        failures++;
        $display("FAIL frame_addr n=%0d got=(%0d,%0d) want=(%0d,%0d)", n_ticks,
                 vif.ADDRH, vif.ADDRV, exp_addrh(n_ticks), exp_addrv(n_ticks));
      end
      checks++;
      if ({vif.HS, vif.VS, vif.COLOUR_OUT} !==
          {!hs_low(n_ticks - 1), !vs_low(n_ticks - 1), vis(n_ticks - 1) ? smp : 8'h00}) begin
        failures++;
        $display("FAIL frame_out n=%0d got=%b%b/%h want=%b%b/%h", n_ticks, vif.HS, vif.VS,
                 vif.COLOUR_OUT, !hs_low(n_ticks - 1), !vs_low(n_ticks - 1),
                 vis(n_ticks - 1) ? smp : 8'h00);
      end
      checks++;
      if (vif.FRAME_START !== (n_ticks % FT == 0)) begin
        failures++;
        $display("FAIL frame_start n=%0d got=%b want=%b", n_ticks, vif.FRAME_START, (n_ticks % FT == 0));
      end
      if (vif.FRAME_START === 1'b1) begin
        fs_seen++;
        if (last_fs != 0) begin
          checks++;
          if (n_ticks - last_fs !== FT) begin
            failures++;
            $display("FAIL frame_period got=%0d want=%0d", n_ticks - last_fs, FT);
          end
        end
        last_fs = n_ticks;
      end
      if (k < FT && vif.VS === 1'b0) vs_cnt++;
      if (int'(vif.ADDRH) > int'(max_h)) max_h = vif.ADDRH;
      if (int'(vif.ADDRV) > int'(max_v)) max_v = vif.ADDRV;
    end
    checks++;
    if (fs_seen !== 2) begin
      failures++;
      $display("FAIL frame_start_count got=%0d want=2", fs_seen);
    end
    checks++;
    if (vs_cnt !== VSW * HT) begin
      failures++;
      $display("FAIL frame_vs_width got=%0d want=%0d", vs_cnt, VSW * HT);
    end
    checks++;
    if (max_h !== HV - 1 || max_v !== VV - 1) begin
      failures++;
      $display("FAIL frame_addr_max got=(%0d,%0d) want=(%0d,%0d)", max_h, max_v, HV - 1, VV - 1);
    end
  endtask

  task automatic test_render();
    bit got, stray; int unsigned cyc; logic [7:0] smp;
    logic [7:0] want;
    mode = 2;
    do_reset(3);
    for (int unsigned k = 0; k < FT + HT; k++) begin
      next_tick(got, cyc, stray, smp);
      if (!got) begin
        checks++; failures++;
        $display("FAIL render_tick_timeout got=0 want=1");
        return;
      end
      want = vis(n_ticks - 1) ? 8'(hpos(n_ticks - 1)) : 8'h00;
      checks++;
      if (vif.COLOUR_OUT !== want) begin
        failures++;
        $display("FAIL render_colour pix=(%0d,%0d) got=%h want=%h", hpos(n_ticks - 1),
                 vpos(n_ticks - 1), vif.COLOUR_OUT, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit got, stray; int unsigned cyc; logic [7:0] smp;
    logic [29:0] obs;
    int unsigned target;
    target = 7 * HT + 20;
    mode = 1;
    do_reset(2);
    while (n_ticks < target) begin
      next_tick(got, cyc, stray, smp);
      if (!got) begin
        checks++; failures++;
        $display("FAIL midreset_tick_timeout got=0 want=1");
        return;
      end
    end
    repeat ($urandom_range(0, CDIV - 1)) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    obs = {vif.ADDRH, vif.ADDRV, vif.HS, vif.VS, vif.COLOUR_OUT, vif.PIX_TICK, vif.FRAME_START};
    checks++;
    if (obs !== {10'd0, 9'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_values got=%h want=%h", obs, {10'd0, 9'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
    end
    RESET = 1'b0;
    n_ticks = 0;
    next_tick(got, cyc, stray, smp);
    checks++;
    if (cyc !== CDIV || !got) begin
      failures++;
      $display("FAIL midreset_phase got=%0d want=%0d", cyc, CDIV);
    end
    checks++;
    if ({vif.ADDRH, vif.ADDRV, vif.COLOUR_OUT, vif.FRAME_START} !== {10'd1, 9'd0, smp, 1'b0}) begin
      failures++;
      $display("FAIL midreset_restart got=(%0d,%0d)/%h/%b want=(1,0)/%h/0", vif.ADDRH, vif.ADDRV,
               vif.COLOUR_OUT, vif.FRAME_START, smp);
    end
  endtask

  task automatic test_vblank();
    bit got, stray; int unsigned cyc; logic [7:0] smp;
    int unsigned leak;
    leak = 0;
    mode = 0; col_const = 8'hA5;
    do_reset(2);
    for (int unsigned k = 0; k < FT; k++) begin
      next_tick(got, cyc, stray, smp);
      if (!got) begin
        checks++; failures++;
        $display("FAIL vblank_tick_timeout got=0 want=1");
        return;
      end
      checks++;
      if (vif.COLOUR_OUT !== (vis(n_ticks - 1) ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("FAIL vblank_colour pix=(%0d,%0d) got=%h want=%h", hpos(n_ticks - 1),
                 vpos(n_ticks - 1), vif.COLOUR_OUT, vis(n_ticks - 1) ? 8'hA5 : 8'h00);
      end
      if (vpos(n_ticks - 1) >= VV && vif.COLOUR_OUT !== 8'h00) leak++;
    end
    checks++;
    if (leak !== 0) begin
      failures++;
      $display("FAIL vblank_leak got=%0d want=0", leak);
    end
  endtask

  initial begin
    vif.COLOUR_IN = 8'h00;
    test_reset();
    test_line();
    test_frame();
    test_render();
    test_mid_reset();
    test_vblank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Raster-scan VGA timing generator and pixel output stage for the snake game display.
- Generates the pixel address (ADDRH/ADDRV) that the game renderer consumes.
- Samples the renderer's 8-bit COLOUR one pixel period later and drives the registered RGB and HS/VS pins.
- Default timing is 640x480 @ 60 Hz, with a 25 MHz pixel rate derived from a 100 MHz CLK.

Parameters:
CLK_DIV, 4, CLK cycles per pixel; must be >= 2.
H_VISIBLE, 640, visible pixels per line.
H_FRONT, 16, horizontal front porch, in pixels.
H_SYNC, 96, horizontal sync width, in pixels.
H_BACK, 48, horizontal back porch, in pixels.
V_VISIBLE, 480, visible lines per frame.
V_FRONT, 10, vertical front porch, in lines.
V_SYNC, 2, vertical sync width, in lines.
V_BACK, 33, vertical back porch, in lines.

Ports:
CLK  in  1  system clock, 100 MHz.
RESET  in  1  synchronous, active-high reset.
COLOUR_IN  in  8  renderer colour for the address currently presented; bit layout {B[7:6], G[5:3], R[2:0]}.
ADDRH  out  10  current horizontal pixel address; 0 outside the visible region.
ADDRV  out  9  current vertical line address; 0 outside the visible region.
HS  out  1  horizontal sync, active low.
VS  out  1  vertical sync, active low.
COLOUR_OUT  out  8  registered pixel colour to the DAC/pins.
PIX_TICK  out  1  one-CLK strobe marking each pixel boundary.
FRAME_START  out  1  one-CLK strobe when the raster returns to (0,0).

Behaviour:
Timing constants:
- H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800).
- V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525).

Reset (RESET=1 at a CLK edge):
- div counter, hcnt and vcnt = 0.
- ADDRH = 0, ADDRV = 0.
- HS = 1, VS = 1.
- COLOUR_OUT = 0.
- PIX_TICK = 0, FRAME_START = 0.
- Reset mid-line or mid-frame takes effect on that edge, with no partial line completion.
- The first PIX_TICK occurs CLK_DIV cycles after RESET deasserts.

Divider:
- div counts 0..CLK_DIV-1 and wraps to 0.
- PIX_TICK is registered high for exactly one CLK in the cycle after div == CLK_DIV-1.
- All raster state below updates only on the CLK edge where div == CLK_DIV-1, called the "tick".

Counters, on each tick:
- hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
- vcnt wraps from V_TOTAL-1 to 0 when hcnt also wraps.
- No other state changes between ticks.

Address outputs, registered from the post-tick counter values:
- ADDRH = hcnt if hcnt < H_VISIBLE, else 0.
- ADDRV = vcnt if vcnt < V_VISIBLE, else 0.
- Addresses are stable for CLK_DIV cycles, so the renderer's one-CLK registered colour is settled before the next tick.

Output stage, registered on the tick from the pre-tick counter values (one-pixel pipeline):
- COLOUR_OUT = COLOUR_IN if pre-tick hcnt < H_VISIBLE and vcnt < V_VISIBLE, else 8'h00 (blanking forced regardless of COLOUR_IN).
- HS = 0 iff pre-tick hcnt is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
- VS = 0 iff pre-tick vcnt is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
- Net effect: HS, VS and COLOUR_OUT all describe the same pixel, one pixel period after its address was presented.

FRAME_START:
- One-CLK pulse, coincident with PIX_TICK, on the tick where hcnt and vcnt both wrap to 0.
- Downstream game logic uses it as the game clock source.

Widths:
- hcnt is 10 bits, vcnt is 10 bits.
- ADDRV is the low 9 bits; visible lines are always < 480.

Test Plan:
- Reset, then run 4 CLK: PIX_TICK first high on the 4th cycle; ADDRH=1 and ADDRV=0 after the first tick; COLOUR_OUT=0, HS=VS=1 throughout reset.
- Hold COLOUR_IN=8'hFF and run one line: COLOUR_OUT=FF for exactly 640 ticks, then 00 for 160 ticks; HS low for exactly 96 ticks, starting on the tick that registers pre-tick hcnt=656.
- Run a full frame, counting PIX_TICK: exactly 420000 ticks (800x525) between consecutive FRAME_START pulses; VS low for 1600 ticks; ADDRV never exceeds 479; ADDRH never exceeds 639.
- Drive COLOUR_IN from a function of the previous-cycle ADDRH/ADDRV (e.g. ADDRH[7:0], registered, as the renderer does): COLOUR_OUT equals the pixel address's low byte one tick later at every visible pixel, e.g. address (10,5) yields 8'h0A.
- Assert RESET for 1 CLK at hcnt=700, vcnt=300: next cycle all outputs are at reset values; the raster restarts from (0,0) with a 4-cycle divider phase.
- Drive COLOUR_IN=8'hA5 during vertical blanking (vcnt 480..524): COLOUR_OUT stays 00 for all of it.
